// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests and a registered
// instruction queue toward decode. Optional static prediction: define STATIC_PRED_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_8000_0000,
  parameter int          FQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_is_pre,
  input  logic        flush,
  input  logic [63:0] flush_pc
);
  localparam int QAW    = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int QCW    = $clog2(FQ_DEPTH + 1);
  localparam int OAW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int QSLOTS = 1 << QAW;
  localparam int OSLOTS = 1 << OAW;

  localparam logic [31:0]    FQ_LIMIT  = 32'(FQ_DEPTH);
  localparam logic [31:0]    OUT_LIMIT = 32'(MAX_OUTSTANDING);
  localparam logic [QCW-1:0] Q_ONE     = QCW'(1);
  localparam logic [QAW-1:0] QA_ONE    = QAW'(1);
  localparam logic [OCW-1:0] O_ONE     = OCW'(1);
  localparam logic [OAW-1:0] OA_ONE    = OAW'(1);

  logic [63:0]    fetch_pc;
  logic [63:0]    fetch_pc_next;
  logic [OCW-1:0] outstanding;
  logic [OCW-1:0] outstanding_next;
  logic [OCW-1:0] drop_cnt;
  logic [OCW-1:0] drop_next;

  // In-flight PC FIFO: one entry per accepted request, popped by each response.
  logic [63:0]    if_pc [OSLOTS];
  logic [OAW-1:0] if_head;
  logic [OAW-1:0] if_tail;

  logic [31:0]    q_inst [QSLOTS];
  logic [63:0]    q_pc   [QSLOTS];
  logic           q_pre  [QSLOTS];
  logic [QAW-1:0] q_head;
  logic [QAW-1:0] q_tail;
  logic [QCW-1:0] q_count;

  logic        can_issue;
  logic        req_fire;
  logic        resp_keep;
  logic        deq;
  logic [63:0] resp_pc;
  logic        resp_pre;
  logic        pred_taken;
  logic [63:0] pred_target;

`ifdef STATIC_PRED_EN
  function automatic logic [63:0] j_imm(input logic [31:0] inst);
    return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [63:0] b_imm(input logic [31:0] inst);
    return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction
`endif

  // Queue slots are reserved at issue time, so a response always has room.
  assign can_issue = (32'(outstanding) < OUT_LIMIT) &&
                     ((32'(q_count) + 32'(outstanding)) < FQ_LIMIT);
  assign imem_req_valid = !reset && !flush && can_issue;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_pc        = if_pc[if_head];
  assign resp_keep      = imem_resp_valid && !flush && (drop_cnt == OCW'(0));
  assign deq            = out_valid && out_ready;

  // Pre-decode of the returning instruction against its in-flight PC.
  always_comb begin
    resp_pre    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 64'h0;
`ifdef STATIC_PRED_EN
    if (imem_resp_data[6:0] == 7'b1101111) begin
      resp_pre    = 1'b1;
      pred_target = resp_pc + j_imm(imem_resp_data);
    end else if ((imem_resp_data[6:0] == 7'b1100011) && imem_resp_data[31]) begin
      resp_pre    = 1'b1;
      pred_target = resp_pc + b_imm(imem_resp_data);
    end else begin
      resp_pre    = 1'b0;
      pred_target = 64'h0;
    end
    pred_taken = resp_keep && resp_pre;
`endif
  end

  // Next fetch PC, in-flight count and count of stale responses still to discard.
  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !imem_resp_valid) begin
      outstanding_next = outstanding + O_ONE;
    end else if (!req_fire && imem_resp_valid) begin
      outstanding_next = outstanding - O_ONE;
    end else begin
      outstanding_next = outstanding;
    end

    drop_next = drop_cnt;
    if (flush) begin
      drop_next = imem_resp_valid ? (outstanding - O_ONE) : outstanding;
    end else if (pred_taken) begin
      drop_next = outstanding_next;
    end else if (imem_resp_valid && (drop_cnt != OCW'(0))) begin
      drop_next = drop_cnt - O_ONE;
    end else begin
      drop_next = drop_cnt;
    end

    fetch_pc_next = fetch_pc;
    if (flush) begin
      fetch_pc_next = flush_pc;
    end else if (pred_taken) begin
      fetch_pc_next = pred_target;
    end else if (req_fire) begin
      fetch_pc_next = fetch_pc + 64'd4;
    end else begin
      fetch_pc_next = fetch_pc;
    end
  end

  // Control state: fetch PC, counters and FIFO/queue pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= OCW'(0);
      drop_cnt    <= OCW'(0);
      if_head     <= OAW'(0);
      if_tail     <= OAW'(0);
      q_head      <= QAW'(0);
      q_tail      <= QAW'(0);
      q_count     <= QCW'(0);
    end else begin
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      if (req_fire) begin
        if_tail <= if_tail + OA_ONE;
      end
      if (imem_resp_valid) begin
        if_head <= if_head + OA_ONE;
      end
      if (flush) begin
        q_head  <= QAW'(0);
        q_tail  <= QAW'(0);
        q_count <= QCW'(0);
      end else begin
        if (resp_keep) begin
          q_tail <= q_tail + QA_ONE;
        end
        if (deq) begin
          q_head <= q_head + QA_ONE;
        end
        if (resp_keep && !deq) begin
          q_count <= q_count + Q_ONE;
        end else if (!resp_keep && deq) begin
          q_count <= q_count - Q_ONE;
        end
      end
    end
  end

  // Storage arrays; contents are don't-care until their pointer covers them.
  always_ff @(posedge clock) begin
    if (req_fire) begin
      if_pc[if_tail] <= fetch_pc;
    end
    if (resp_keep) begin
      q_inst[q_tail] <= imem_resp_data;
      q_pc[q_tail]   <= resp_pc;
      q_pre[q_tail]  <= resp_pre;
    end
  end

  assign out_valid  = (q_count != QCW'(0));
  assign out_inst   = out_valid ? q_inst[q_head] : 32'h0;
  assign out_pc     = out_valid ? q_pc[q_head]   : 64'h0;
  assign out_is_pre = out_valid ? q_pre[q_head]  : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order stream model against a latency-randomised memory.
module tb_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int FQ_DEPTH = 4;
  localparam int MAX_OUT  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_is_pre;
  logic        flush;
  logic [63:0] flush_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_is_pre(out_is_pre), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Instruction memory: a few overrides plus an address-derived program.
  logic [31:0] ov [logic [63:0]];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (ov.exists(a)) return ov[a];
    case (a[5:2])
      4'd3:    return 32'h0400_006F;   // jal x0, +64
      4'd9:    return 32'hFE00_0CE3;   // beq x0, x0, -8
      4'd12:   return 32'h0000_0463;   // beq forward
      default: return {a[31:7] ^ 25'h1A5_A5A5, 7'b0010011};
    endcase
  endfunction

  function automatic logic predicted(input logic [31:0] i);
`ifdef STATIC_PRED_EN
    return (i[6:0] == 7'b1101111) || ((i[6:0] == 7'b1100011) && i[31]);
`else
    return 1'b0;
`endif
  endfunction

  // Program-order successor of an instruction as decode should see it.
  function automatic logic [63:0] next_pc(input logic [63:0] pc, input logic [31:0] i);
    logic signed [63:0] off;
    if (!predicted(i)) return pc + 64'd4;
    if (i[6:0] == 7'b1101111) off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
    else                      off = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
    return pc + off;
  endfunction

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic pre; } pop_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; logic pre; logic [63:0] nxt; } vec_t;

  mreq_t       mq[$];
  logic [63:0] req_log[$];
  pop_t        pop_log[$];
  int          cyc = 0, accepts = 0, resps = 0, pops = 0;
  int          first_req_cyc = -1, first_pop_cyc = -1;
  int          lat_min = 1, lat_max = 1, ready_pct = 100;
  bit          hold_resp = 1'b0;
  bit          last_resp = 1'b0;
  logic [63:0] exp_pc;

  // One clock: drive inputs at the falling edge, observe what the next rising edge commits.
  task automatic cycle(input bit ordy, input bit fl, input logic [63:0] fpc);
    mreq_t m;
    pop_t  e;
    logic [31:0] w;
    @(negedge clock);
    out_ready      = ordy;
    flush          = fl;
    flush_pc       = fpc;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    if (!hold_resp && (mq.size() > 0) && (mq[0].due <= cyc)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
      resps++;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    last_resp = imem_resp_valid;
    #1;
    if (fl) check("no_req_in_flush", imem_req_valid, 1'b0);
    if (imem_req_valid && imem_req_ready) begin
      m.addr = imem_req_addr;
      m.due  = cyc + $urandom_range(lat_max, lat_min);
      mq.push_back(m);
      req_log.push_back(imem_req_addr);
      if (accepts == 0) first_req_cyc = cyc;
      accepts++;
    end
    check("outstanding_bound", (accepts - resps) <= MAX_OUT, 1'b1);
    if (out_valid && out_ready) begin
      w = mem_word(exp_pc);
      check("out_pc", out_pc, exp_pc);
      check("out_inst", out_inst, w);
      check("out_is_pre", out_is_pre, predicted(w));
      e.pc  = out_pc;
      e.pre = out_is_pre;
      pop_log.push_back(e);
      if (pops == 0) first_pop_cyc = cyc;
      pops++;
      exp_pc = next_pc(exp_pc, w);
    end
    if (fl) exp_pc = fpc;
    cyc++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int   n, p, a0;
    bit   ok;
    logic exp_pre;
    logic [63:0] exp_nxt;

    vt[0] = '{pc: 64'h0000_0000_8000_0000, inst: 32'h1000_006F, pre: 1'b1, nxt: 64'h0000_0000_8000_0100};
    vt[1] = '{pc: 64'h0000_0000_8000_0010, inst: 32'hFE00_0EE3, pre: 1'b1, nxt: 64'h0000_0000_8000_000C};
    vt[2] = '{pc: 64'h0000_0000_8000_0020, inst: 32'h0000_0463, pre: 1'b0, nxt: 64'h0000_0000_8000_0024};
    vt[3] = '{pc: 64'h0000_0000_8000_0030, inst: 32'h0000_00E7, pre: 1'b0, nxt: 64'h0000_0000_8000_0034};
    vt[4] = '{pc: 64'h0000_0000_8000_0040, inst: 32'hFFDF_F06F, pre: 1'b1, nxt: 64'h0000_0000_8000_003C};
    vt[5] = '{pc: 64'h0000_0000_8000_0050, inst: 32'hFE00_1EE3, pre: 1'b1, nxt: 64'h0000_0000_8000_004C};
    vt[6] = '{pc: 64'hFFFF_FFFF_FFFF_FFFC, inst: 32'h0000_0013, pre: 1'b0, nxt: 64'h0000_0000_0000_0000};

    reset = 1'b1; out_ready = 1'b0; flush = 1'b0; flush_pc = 64'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      check("rst_req_valid", imem_req_valid, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_inst", out_inst, 32'h0);
      check("rst_out_pc", out_pc, 64'h0);
      check("rst_out_is_pre", out_is_pre, 1'b0);
    end
    reset  = 1'b0;
    exp_pc = RESET_PC;

    // Sequential fetch with a 1-cycle memory.
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 64'h0);
    check("seq_req0", req_log[0], 64'h0000_0000_8000_0000);
    check("seq_req1", req_log[1], 64'h0000_0000_8000_0004);
    check("seq_req2", req_log[2], 64'h0000_0000_8000_0008);
    check("resp_to_out_latency", first_pop_cyc - first_req_cyc, 2);

    // Decode stalls: queue fills and issue stops, then drains in order.
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 64'h0);
    check("full_req_valid_low", imem_req_valid, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    check("full_none_outstanding", accepts - resps, 0);
    p = pops; a0 = accepts;
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 64'h0);
    check("drain_four_pops", pops - p, 4);
    check("fetch_resumes", (accepts - a0) > 0, 1'b1);

    // Flush with two requests in flight and no response that cycle.
    lat_min = 2; lat_max = 2;
    hold_resp = 1'b1; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle(1'b1, 1'b0, 64'h0);
      ok = ((accepts - resps) == 2);
    end
    check("t3_two_outstanding", ok, 1'b1);
    n = req_log.size();
    cycle(1'b1, 1'b1, 64'h0000_0000_8000_1000);
    hold_resp = 1'b0;
    for (int k = 0; k < 20 && (req_log.size() <= n); k++) cycle(1'b1, 1'b0, 64'h0);
    check("t3_redirect_addr", (req_log.size() > n) ? req_log[n] : 64'hDEAD, 64'h0000_0000_8000_1000);
    p = pops;
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 64'h0);
    check("t3_progress", (pops - p) > 0, 1'b1);

    // Flush coinciding with a response while two are in flight.
    lat_min = 1; lat_max = 1;
    hold_resp = 1'b1; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle(1'b1, 1'b0, 64'h0);
      ok = ((accepts - resps) == 2);
    end
    check("t4_two_outstanding", ok, 1'b1);
    hold_resp = 1'b0;
    n = req_log.size();
    cycle(1'b1, 1'b1, 64'h0000_0000_8000_2000);
    check("t4_resp_with_flush", last_resp, 1'b1);
    for (int k = 0; k < 20 && (req_log.size() <= n); k++) cycle(1'b1, 1'b0, 64'h0);
    check("t4_redirect_addr", (req_log.size() > n) ? req_log[n] : 64'hDEAD, 64'h0000_0000_8000_2000);
    p = pop_log.size();
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 64'h0);
    check("t4_first_kept_pc", (pop_log.size() > p) ? pop_log[p].pc : 64'hDEAD, 64'h0000_0000_8000_2000);

    // Table: one instruction at a redirect target, check its flag and successor.
    for (int v = 0; v < 7; v++) begin
`ifdef STATIC_PRED_EN
      exp_pre = vt[v].pre;
      exp_nxt = vt[v].nxt;
`else
      exp_pre = 1'b0;
      exp_nxt = vt[v].pc + 64'd4;
`endif
      ov[vt[v].pc] = vt[v].inst;
      cycle(1'b1, 1'b1, vt[v].pc);
      p = pop_log.size();
      for (int k = 0; k < 40 && (pop_log.size() < p + 2); k++) cycle(1'b1, 1'b0, 64'h0);
      ok = (pop_log.size() >= p + 2);
      check($sformatf("vec%0d_two_pops", v), ok, 1'b1);
      if (ok) begin
        check($sformatf("vec%0d_pc", v), pop_log[p].pc, vt[v].pc);
        check($sformatf("vec%0d_is_pre", v), pop_log[p].pre, exp_pre);
        check($sformatf("vec%0d_next_pc", v), pop_log[p+1].pc, exp_nxt);
      end
    end

    // Random traffic: memory latency, stalls, backpressure and flushes.
    ov.delete();
    lat_min = 1; lat_max = 4; ready_pct = 70;
    p = pops;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) < 2) begin
        if ($urandom_range(3) == 0) cycle($urandom_range(99) < 75, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
        else cycle($urandom_range(99) < 75, 1'b1, {$urandom, $urandom} & ~64'h3);
      end else begin
        cycle($urandom_range(99) < 75, 1'b0, 64'h0);
      end
    end
    check("rand_progress", (pops - p) > 100, 1'b1);
    ready_pct = 100;
    p = pops;
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, 64'h0);
    check("drain_progress", (pops - p) > 10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
